// File: rtl/dma_reg_slave.sv
// dma_reg_slave: register-file target for the DMA control bus.
// Holds the DMA programming registers and a word-count transfer engine
// (IDLE/RUN) that reports busy/done status and a level interrupt.
// Optional feature: define DMA_REG_ABORT_EN to enable the CTRL[2] abort pulse.
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | engine stopped, waiting for a start write
// S_RUN  | transfer in progress, COUNT decrements each cycle

module dma_reg_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h444D_4101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        intr,
    output logic        busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] W_CTRL   = 6'h00;
    localparam logic [5:0] W_STATUS = 6'h01;
    localparam logic [5:0] W_SRC    = 6'h02;
    localparam logic [5:0] W_DST    = 6'h03;
    localparam logic [5:0] W_LEN    = 6'h04;
    localparam logic [5:0] W_COUNT  = 6'h05;
    localparam logic [5:0] W_ID     = 6'h06;

    state_t      state_q;
    state_t      state_d;

    logic        intr_en_q;
    logic        intr_en_d;
    logic        done_q;
    logic        done_d;
    logic        err_q;
    logic        err_d;
    logic        aborted_q;
    logic        aborted_d;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [31:0] rdata_q;
    logic        intr_q;

    logic        hit;
    logic [5:0]  word;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_src;
    logic        wr_dst;
    logic        wr_len;
    logic        start_req;
    logic        abort_req;
    logic        go_start;
    logic        zero_start;
    logic        finish;
    logic        abort_hit;
    logic [31:0] rd_val;

    // addr[1:0] carries no meaning on a word-aligned bus
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    // address decode and write strobes
    always_comb begin
        hit       = (addr[31:8] == BASE_ADDR[31:8]);
        word      = addr[7:2];
        wr_ctrl   = wr_en && hit && (word == W_CTRL);
        wr_status = wr_en && hit && (word == W_STATUS);
        wr_src    = wr_en && hit && (word == W_SRC);
        wr_dst    = wr_en && hit && (word == W_DST);
        wr_len    = wr_en && hit && (word == W_LEN);
        start_req = wr_ctrl && wdata[0];
`ifdef DMA_REG_ABORT_EN
        // a combined start+abort write is treated as a start only
        abort_req = wr_ctrl && wdata[2] && !wdata[0];
`else
        abort_req = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_req && (len_q != 16'd0)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_req || (count_q == 16'd1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: engine events consumed by the register datapath
    always_comb begin
        busy       = (state_q == S_RUN);
        go_start   = (state_q == S_IDLE) && start_req && (len_q != 16'd0);
        zero_start = (state_q == S_IDLE) && start_req && (len_q == 16'd0);
        abort_hit  = (state_q == S_RUN) && abort_req;
        finish     = (state_q == S_RUN) && (count_q == 16'd1) && !abort_req;
    end

    // next values of status/control bits; set events override W1C clears
    always_comb begin
        intr_en_d = wr_ctrl ? wdata[1] : intr_en_q;

        done_d = done_q;
        if (wr_status && wdata[1]) done_d = 1'b0;
        if (go_start)              done_d = 1'b0;
        if (zero_start || finish)  done_d = 1'b1;

        err_d = err_q;
        if (wr_status && wdata[2]) err_d = 1'b0;
        if (go_start)              err_d = 1'b0;
        if (zero_start)            err_d = 1'b1;

`ifdef DMA_REG_ABORT_EN
        aborted_d = aborted_q;
        if (wr_status && wdata[3]) aborted_d = 1'b0;
        if (go_start)              aborted_d = 1'b0;
        if (abort_hit)             aborted_d = 1'b1;
`else
        aborted_d = 1'b0;
`endif
    end

    // programming registers, status bits and the interrupt flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_en_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            len_q     <= 16'd0;
            intr_q    <= 1'b0;
        end else begin
            intr_en_q <= intr_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            intr_q    <= done_d && intr_en_d;
            if (wr_src && !busy) src_q <= wdata;
            if (wr_dst && !busy) dst_q <= wdata;
            if (wr_len && !busy) len_q <= wdata[15:0];
        end
    end

    // remaining-word counter; on abort it takes this cycle's decrement then holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else if (go_start) begin
            count_q <= len_q;
        end else if (busy) begin
            count_q <= count_q - 16'd1;
        end
    end

    // read mux; unmapped offsets and base misses return zero
    always_comb begin
        rd_val = 32'd0;
        if (hit) begin
            case (word)
                W_CTRL:   rd_val = {30'd0, intr_en_q, 1'b0};
                W_STATUS: rd_val = {28'd0, aborted_q, err_q, done_q, busy};
                W_SRC:    rd_val = src_q;
                W_DST:    rd_val = dst_q;
                W_LEN:    rd_val = {16'd0, len_q};
                W_COUNT:  rd_val = {16'd0, count_q};
                W_ID:     rd_val = ID_VALUE;
                default:  rd_val = 32'd0;
            endcase
        end
    end

    // registered read data, held while rd_en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'd0;
        end else if (rd_en) begin
            rdata_q <= rd_val;
        end
    end

    assign rdata = rdata_q;
    assign intr  = intr_q;

endmodule
